dma_rd_port: RTL
================

// Module: dma_rd_port
// PURPOSE
//  Read-side DMA channel feeding the engine's data/weight input ports (p2..p5).
//  Turns the engine's level request (reads_en + 30-bit address) into single-word
//  read commands on a 32-bit memory-controller user port. Returns one 16-bit
//  operand per request on ob_data with a one-cycle ob_we strobe.
//  A one-word line cache serves the second halfword of a fetched word without a
//  new memory command.
// PARAMETERS
//  ADDR_W   30    byte-address width on both engine and memory side
//  TIMEOUT  1023  max cycles in WAIT before err is raised (10-bit counter)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  reads_en     in   1       engine read request, level; held while more operands needed
//  addr         in   ADDR_W  byte address of requested halfword; bit0 ignored
//  ob_data      out  16      operand returned to engine
//  ob_we        out  1       one-cycle strobe, ob_data valid
//  cmd_en       out  1       memory command strobe
//  cmd_instr    out  3       3'b001 (read) whenever cmd_en=1
//  cmd_bl       out  6       burst length-1, always 0 (one 32-bit word)
//  cmd_addr     out  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}
//  cmd_full     in   1       memory command FIFO full
//  rd_en        out  1       pop memory read-data FIFO
//  rd_data      in   32      memory read data
//  rd_empty     in   1       memory read-data FIFO empty
//  err          out  1       sticky read-timeout flag, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; cache tag invalid; timeout counter 0.
//  States IDLE, CMD, WAIT, DLV, GAP.
//  IDLE: if reads_en, latch addr -> req_addr.
//    Cache hit (tag valid and tag == req_addr[ADDR_W-1:2]) -> DLV.
//    Miss -> CMD.
//  CMD: drive cmd_en=1 in a cycle where cmd_full=0, then -> WAIT.
//    cmd_en stays 0 while cmd_full=1; never assert cmd_en while cmd_full=1.
//  WAIT: on first cycle with rd_empty=0:
//    rd_en=1 for exactly that cycle; capture rd_data into cache word.
//    Set tag = req_addr[ADDR_W-1:2], tag valid; -> DLV.
//    Counter increments each WAIT cycle; on reaching TIMEOUT, err<=1 but keep
//    waiting (no abort).
//  DLV: ob_data = req_addr[1] ? cache[31:16] : cache[15:0]; ob_we=1 for one
//    cycle, only if reads_en is still 1 (else suppressed, cache still updated);
//    -> GAP.
//  GAP: one idle cycle so the engine can advance addr; -> IDLE.
//  Latency, reads_en high to ob_we:
//    hit: 2 cycles.
//    miss: 4 + cmd_full stall cycles + rd_empty wait cycles.
//  Throughput: at most one ob_we per 3 cycles (hit); matches engine pacing.
//  addr changes while not in IDLE are ignored; req_addr is held.
//  reads_en dropping mid-miss: the command and pop still complete (no orphan
//    FIFO data); only ob_we is suppressed.
//  Cache is invalidated only by rst; no write-side coherence (engine never reads
//    an address it writes in the same op).
//  Reset mid-operation: returns to IDLE next cycle. The memory controller shares
//    rst and flushes its own FIFOs.
//  Address wrap: cmd_addr computed modulo 2^ADDR_W; no carry handling.
// TESTING
//  1 Miss, zero stall: addr=0x10000, rd_data=0xBBBBAAAA 2 cycles after cmd ->
//    cmd_addr=0x10000, one rd_en, ob_data=0xAAAA, ob_we single pulse.
//  2 Hit: follow with addr=0x10002 -> no cmd_en, ob_we 2 cycles after IDLE,
//    ob_data=0xBBBB.
//  3 Backpressure: cmd_full=1 for 5 cycles -> cmd_en only after cmd_full falls,
//    exactly one command issued.
//  4 Drop: reads_en low while in WAIT -> rd_en still pulses once, ob_we stays 0;
//    next request to same word hits.
//  5 Timeout: rd_empty held 1 for 1100 cycles -> err=1 at cycle 1023 of WAIT;
//    data then arrives and is delivered; err stays 1 until rst.
//  6 Reset in WAIT: rst one cycle -> all outputs 0, tag invalid; next request to
//    same addr issues a fresh command.

Source files
------------

// File: rtl/dma_rd_port_if.sv
// dma_rd_port_if: engine read request/operand return plus memory command and read-data FIFO signals
interface dma_rd_port_if #(
    parameter int ADDR_W = 30
);
    logic              reads_en;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       ob_data;
    logic              ob_we;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_full;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic              rd_empty;
    logic              err;
    modport slave (
        input  reads_en, addr, cmd_full, rd_data, rd_empty,
        output ob_data, ob_we, cmd_en, cmd_instr, cmd_bl, cmd_addr, rd_en, err
    );
    modport master (
        output reads_en, addr, cmd_full, rd_data, rd_empty,
        input  ob_data, ob_we, cmd_en, cmd_instr, cmd_bl, cmd_addr, rd_en, err
    );
endinterface

// File: rtl/dma_rd_port.sv
// dma_rd_port: halfword read requests to single-word memory reads with a one-word line cache
module dma_rd_port #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 1023
) (
    input logic          clk,
    input logic          rst,
    dma_rd_port_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, WAIT, DLV, GAP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:1] req_addr_q, req_addr_d;
    logic [31:0]       cache_q, cache_d;
    logic [ADDR_W-1:2] tag_q, tag_d;
    logic              tag_v_q, tag_v_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       ob_data_q, ob_data_d;
    logic              ob_we_q, ob_we_d;
    logic              hit, cmd_en, rd_en;
    logic              unused;
    assign unused = bus.addr[0];
    assign hit = tag_v_q && tag_q == bus.addr[ADDR_W-1:2];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            cache_q    <= '0;
            tag_q      <= '0;
            tag_v_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ob_data_q  <= '0;
            ob_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cache_q    <= cache_d;
            tag_q      <= tag_d;
            tag_v_q    <= tag_v_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ob_data_q  <= ob_data_d;
            ob_we_q    <= ob_we_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.reads_en) state_d = hit ? DLV : CMD;
            CMD:     if (!bus.cmd_full) state_d = WAIT;
            WAIT:    if (!bus.rd_empty) state_d = DLV;
            DLV:     state_d = GAP;
            default: state_d = IDLE;
        endcase
    end
    // The timeout only flags; the fetch keeps waiting so no FIFO word is ever orphaned.
    always_comb begin
        cmd_en     = state_q == CMD && !bus.cmd_full;
        rd_en      = state_q == WAIT && !bus.rd_empty;
        req_addr_d = state_q == IDLE && bus.reads_en ? bus.addr[ADDR_W-1:1] : req_addr_q;
        cache_d    = rd_en ? bus.rd_data : cache_q;
        tag_d      = rd_en ? req_addr_q[ADDR_W-1:2] : tag_q;
        tag_v_d    = tag_v_q | rd_en;
        cnt_d      = state_q != WAIT ? '0 : cnt_q == 10'(TIMEOUT) ? cnt_q : cnt_q + 10'd1;
        err_d      = err_q | (state_q == WAIT && cnt_d == 10'(TIMEOUT));
        ob_we_d    = state_q == DLV && bus.reads_en;
        ob_data_d  = state_q != DLV ? ob_data_q : req_addr_q[1] ? cache_q[31:16] : cache_q[15:0];
    end
    assign bus.cmd_en    = cmd_en;
    assign bus.cmd_instr = cmd_en ? 3'b001 : 3'b000;
    assign bus.cmd_bl    = '0;
    assign bus.cmd_addr  = {req_addr_q[ADDR_W-1:2], 2'b00};
    assign bus.rd_en     = rd_en;
    assign bus.err       = err_q;
    assign bus.ob_data   = ob_data_q;
    assign bus.ob_we     = ob_we_q;
endmodule
